// File: rtl/scan_chain_driver_pkg.sv
// Shared types, defaults and chain-slot arithmetic for the scan chain driver.
package scan_chain_driver_pkg;

   localparam int unsigned DEF_NUM_DESIGNS = 249;
   localparam int unsigned DEF_NUM_IOS     = 8;
   localparam int unsigned DEF_CLK_DIV     = 2;
   localparam int unsigned SEL_W           = 9;

   // Returned by slot_offset when a shift index does not belong to the selected design.
   localparam logic [31:0] NO_SLOT = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CAPTURE = 3'd1,
      ST_SHIFT   = 3'd2,
      ST_LATCH   = 3'd3,
      ST_DONE    = 3'd4
   } scan_state_e;

   // Bit b of design sel sits at chain position sel*ios+b. The bit shifted during
   // period n lands at position len-1-n, and the bit read back during period n
   // was captured at that same position. Returns b, or NO_SLOT when outside sel.
   function automatic logic [31:0] slot_offset(input logic [31:0] n,
                                               input logic [31:0] sel,
                                               input logic [31:0] num_designs,
                                               input logic [31:0] num_ios);
      logic [31:0] len;
      logic [31:0] pos;
      logic [31:0] base;
      len         = num_designs * num_ios;
      base        = sel * num_ios;
      pos         = '0;
      slot_offset = NO_SLOT;
      if ((sel < num_designs) && (n < len)) begin
         pos = len - 32'd1 - n;
         if ((pos >= base) && (pos < (base + num_ios))) begin
            slot_offset = pos - base;
         end
      end
   endfunction

endpackage

// File: rtl/scan_chain_driver_clk_gen.sv
// Scan clock divider: 2*CLK_DIV clk per scan period, low half first.
// The scan clock level is registered; the strobes decode the current phase.
module scan_chain_driver_clk_gen #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic clk_en,
   output logic scan_clk,
   output logic sample_strobe_c,
   output logic period_end_c
);

   localparam int unsigned PERIOD = 2 * CLK_DIV;
   localparam int unsigned CNT_W  = $clog2(PERIOD);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Phase decode: last clk of the low half, last clk of the period.
   assign sample_strobe_c = (cnt_q == CNT_W'(CLK_DIV - 1));
   assign period_end_c    = (cnt_q == CNT_W'(PERIOD - 1));

   // Next phase; restart forces the start of a low half.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (restart || period_end_c) begin
         cnt_d = '0;
      end
   end

   // Phase counter and registered scan clock level aligned with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         scan_clk <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         scan_clk <= clk_en && (cnt_d >= CNT_W'(CLK_DIV));
      end
   end

endmodule

// File: rtl/scan_chain_driver.sv
// Daisy-chain initiator: per frame capture all design outputs, shift fresh
// inputs to the selected design while reading its captured outputs, then latch.
module scan_chain_driver
   import scan_chain_driver_pkg::*;
#(
   parameter int unsigned NUM_DESIGNS = DEF_NUM_DESIGNS,
   parameter int unsigned NUM_IOS     = DEF_NUM_IOS,
   parameter int unsigned CLK_DIV     = DEF_CLK_DIV
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [SEL_W-1:0]   active_select,
   input  logic [NUM_IOS-1:0] inputs,
   output logic [NUM_IOS-1:0] outputs,
   output logic               ready,
   output logic               scan_clk_out,
   output logic               scan_data_out,
   output logic               scan_select,
   output logic               scan_latch_en,
   input  logic               scan_data_in
);

   localparam int unsigned SCAN_LEN = NUM_DESIGNS * NUM_IOS;
   localparam int unsigned CNT_W    = $clog2(SCAN_LEN + 1);
   localparam int unsigned BIT_W    = (NUM_IOS > 1) ? $clog2(NUM_IOS) : 1;

   scan_state_e        state_q;
   scan_state_e        state_d;
   logic [CNT_W-1:0]   shift_cnt_q;
   logic [CNT_W-1:0]   shift_cnt_d;
   logic [SEL_W-1:0]   sel_q;
   logic [NUM_IOS-1:0] in_q;
   logic [NUM_IOS-1:0] out_q;

   logic               cap_entry_c;
   logic               clk_en_c;
   logic               sample_strobe_c;
   logic               period_end_c;
   logic [31:0]        drv_off_c;
   logic [31:0]        smp_off_c;
   logic               drv_hit_c;
   logic               smp_hit_c;
   logic               drv_bit_c;
   logic               sel_valid_c;

   scan_chain_driver_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk             (clk),
      .reset           (reset),
      .restart         (cap_entry_c),
      .clk_en          (clk_en_c),
      .scan_clk        (scan_clk_out),
      .sample_strobe_c (sample_strobe_c),
      .period_end_c    (period_end_c)
   );

   // Frame sequencing; the shift index never wraps and restarts on capture entry.
   always_comb begin
      state_d     = state_q;
      shift_cnt_d = shift_cnt_q;
      cap_entry_c = 1'b0;
      clk_en_c    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (period_end_c) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (period_end_c) begin
               if (shift_cnt_q == CNT_W'(SCAN_LEN - 1)) begin
                  state_d = ST_LATCH;
               end else begin
                  shift_cnt_d = shift_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_LATCH: begin
            if (period_end_c) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_CAPTURE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if ((state_d == ST_CAPTURE) && (state_q != ST_CAPTURE)) begin
         cap_entry_c = 1'b1;
         shift_cnt_d = '0;
      end
      clk_en_c = (state_d == ST_CAPTURE) || (state_d == ST_SHIFT);
   end

   // Chain position decode for the bit driven next and the bit sampled now.
   always_comb begin
      drv_off_c   = slot_offset(32'(shift_cnt_d), 32'(sel_q), 32'(NUM_DESIGNS), 32'(NUM_IOS));
      smp_off_c   = slot_offset(32'(shift_cnt_q), 32'(sel_q), 32'(NUM_DESIGNS), 32'(NUM_IOS));
      drv_hit_c   = (drv_off_c < 32'(NUM_IOS));
      smp_hit_c   = (smp_off_c < 32'(NUM_IOS));
      drv_bit_c   = drv_hit_c && in_q[drv_off_c[BIT_W-1:0]];
      sel_valid_c = (32'(sel_q) < 32'(NUM_DESIGNS));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         shift_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         shift_cnt_q <= shift_cnt_d;
      end
   end

   // Frame request capture and serial read-back assembly.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q <= '0;
         in_q  <= '0;
         out_q <= '0;
      end else if (cap_entry_c) begin
         sel_q <= active_select;
         in_q  <= inputs;
         out_q <= '0;
      end else if ((state_q == ST_SHIFT) && sample_strobe_c && smp_hit_c) begin
         out_q[smp_off_c[BIT_W-1:0]] <= scan_data_in;
      end
   end

   // Registered chain controls and host result, aligned with the state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_select   <= 1'b0;
         scan_latch_en <= 1'b0;
         scan_data_out <= 1'b0;
         ready         <= 1'b0;
         outputs       <= '0;
      end else begin
         scan_select   <= (state_d == ST_CAPTURE);
         scan_latch_en <= (state_d == ST_LATCH);
         scan_data_out <= (state_d == ST_SHIFT) && drv_bit_c;
         ready         <= (state_d == ST_DONE);
         if (state_d == ST_DONE) begin
            outputs <= sel_valid_c ? out_q : '0;
         end
      end
   end

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver: a 4-element scan chain model (element 0 inverts,
// the rest loop back) and a per-design latch reference model.
module tb_scan_chain_driver;

   localparam int unsigned ND    = 4;
   localparam int unsigned IOS   = 8;
   localparam int unsigned CD    = 2;
   localparam int unsigned L     = ND * IOS;
   localparam int unsigned FRAME = 2 * CD * (L + 2) + 1;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [8:0] active_select = 9'd0;
   logic [7:0] inputs        = 8'hA5;
   logic [7:0] outputs;
   logic       ready;
   logic       scan_clk_out;
   logic       scan_data_out;
   logic       scan_select;
   logic       scan_latch_en;
   logic       scan_data_in;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   scan_chain_driver #(
      .NUM_DESIGNS (ND),
      .NUM_IOS     (IOS),
      .CLK_DIV     (CD)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .active_select (active_select),
      .inputs        (inputs),
      .outputs       (outputs),
      .ready         (ready),
      .scan_clk_out  (scan_clk_out),
      .scan_data_out (scan_data_out),
      .scan_select   (scan_select),
      .scan_latch_en (scan_latch_en),
      .scan_data_in  (scan_data_in)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scan chain model: position p = element*IOS + bit, position 0 nearest the driver.
   logic [L-1:0] chain_ff  = '0;
   logic [L-1:0] chain_lat = '0;
   assign scan_data_in = chain_ff[L-1];

   function automatic logic [L-1:0] module_outs(input logic [L-1:0] lat);
      logic [L-1:0] r;
      r          = lat;
      r[IOS-1:0] = ~lat[IOS-1:0];
      return r;
   endfunction

   always @(posedge scan_clk_out) begin
      if (scan_select) chain_ff <= module_outs(chain_lat);
      else             chain_ff <= {chain_ff[L-2:0], scan_data_out};
   end

   always @(posedge clk) begin
      if (scan_latch_en) chain_lat <= chain_ff;
   end

   // Reference: what each design's latches hold after every completed frame.
   logic [7:0] ref_lat [ND];
   logic [8:0] cap_sel   = '0;
   logic [7:0] cap_in    = '0;
   logic       first_cap = 1'b1;

   // Request taken at the edge that starts each frame.
   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            first_cap = 1'b1;
         end else if (first_cap || ready) begin
            cap_sel   = active_select;
            cap_in    = inputs;
            first_cap = 1'b0;
         end
      end
   end

   // Per-frame protocol tallies and result check at each ready.
   initial begin
      int   sel_clks, lat_clks, rises, ones, viol, since_ready;
      bit   have_prev;
      logic prev_sel, prev_lat, prev_clk;
      logic [7:0] exp_out;
      sel_clks = 0; lat_clks = 0; rises = 0; ones = 0; viol = 0; since_ready = 0;
      have_prev = 1'b0; prev_sel = 1'b0; prev_lat = 1'b0; prev_clk = 1'b0;
      for (int i = 0; i < int'(ND); i++) ref_lat[i] = 8'h00;
      forever begin
         @(negedge clk);
         if (reset) begin
            sel_clks = 0; lat_clks = 0; rises = 0; ones = 0; viol = 0; since_ready = 0;
            have_prev = 1'b0; prev_sel = 1'b0; prev_lat = 1'b0; prev_clk = 1'b0;
         end else begin
            since_ready++;
            if (scan_select)   sel_clks++;
            if (scan_latch_en) lat_clks++;
            if (scan_data_out) ones++;
            if (scan_clk_out && !prev_clk) rises++;
            if (scan_select && scan_latch_en) viol++;
            if (((scan_select != prev_sel) || (scan_latch_en != prev_lat)) && scan_clk_out) viol++;
            prev_sel = scan_select;
            prev_lat = scan_latch_en;
            prev_clk = scan_clk_out;
            if (ready) begin
               if (cap_sel < 9'(ND)) exp_out = (cap_sel == 9'd0) ? ~ref_lat[0] : ref_lat[cap_sel[1:0]];
               else                  exp_out = 8'h00;
               check_eq("outputs", 32'(outputs), 32'(exp_out));
               check_eq("select_clks", 32'(sel_clks), 32'(2 * CD));
               check_eq("latch_clks", 32'(lat_clks), 32'(2 * CD));
               check_eq("scan_rises", 32'(rises), 32'(L + 1));
               check_eq("data_high_clks", 32'(ones),
                        (cap_sel < 9'(ND)) ? 32'(2 * CD * $countones(cap_in)) : 32'd0);
               check_eq("protocol", 32'(viol), 32'd0);
               if (have_prev) check_eq("frame_len", 32'(since_ready), 32'(FRAME));
               for (int i = 0; i < int'(ND); i++) ref_lat[i] = 8'h00;
               if (cap_sel < 9'(ND)) ref_lat[cap_sel[1:0]] = cap_in;
               sel_clks = 0; lat_clks = 0; rises = 0; ones = 0; viol = 0; since_ready = 0;
               have_prev = 1'b1;
            end
         end
      end
   end

   task automatic wait_ready(input int max_clk);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!ready && (k < max_clk));
      if (!ready) check_eq("ready_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Power-up reset, then sel 0 with 0xA5.
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_eq("idle_after_reset", 32'(scan_select), 32'd0);
      @(negedge clk);
      check_eq("capture_after_idle", 32'(scan_select), 32'd1);
      wait_ready(2 * FRAME);
      check_eq("first_out_sel0", 32'(outputs), 32'hFF);
      wait_ready(2 * FRAME);
      check_eq("second_out_sel0", 32'(outputs), 32'h5A);

      // Last element, other latches must end up cleared.
      active_select = 9'd3;
      inputs        = 8'h3C;
      wait_ready(2 * FRAME);
      wait_ready(2 * FRAME);
      check_eq("out_sel3", 32'(outputs), 32'h3C);
      check_eq("latches_0_to_2", 32'(chain_lat[3*IOS-1:0]), 32'd0);

      // Mid-frame input change only affects the following frame.
      active_select = 9'd1;
      inputs        = 8'h11;
      repeat (60) @(negedge clk);
      inputs        = 8'h22;
      wait_ready(2 * FRAME);
      wait_ready(2 * FRAME);
      check_eq("out_sel1_first", 32'(outputs), 32'h11);
      wait_ready(2 * FRAME);
      check_eq("out_sel1_second", 32'(outputs), 32'h22);

      // Out-of-range selection.
      active_select = 9'd9;
      inputs        = 8'hFF;
      wait_ready(2 * FRAME);
      check_eq("out_sel9", 32'(outputs), 32'h00);
      wait_ready(2 * FRAME);

      // Reset mid-shift.
      active_select = 9'd2;
      inputs        = 8'h96;
      repeat (40) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_outputs", 32'(outputs), 32'd0);
      check_eq("rst_ready", 32'(ready), 32'd0);
      check_eq("rst_scan_clk", 32'(scan_clk_out), 32'd0);
      check_eq("rst_scan_data", 32'(scan_data_out), 32'd0);
      check_eq("rst_scan_select", 32'(scan_select), 32'd0);
      check_eq("rst_latch_en", 32'(scan_latch_en), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_eq("idle_after_release", 32'(scan_select), 32'd0);
      @(negedge clk);
      check_eq("capture_after_release", 32'(scan_select), 32'd1);
      wait_ready(2 * FRAME);

      // Randomized frames, some with a mid-frame input change.
      for (int f = 0; f < 10; f++) begin
         if ($urandom_range(0, 4) == 0) active_select = 9'($urandom_range(4, 511));
         else                           active_select = 9'($urandom_range(0, ND - 1));
         inputs = 8'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(5, 100)) @(negedge clk);
            inputs = 8'($urandom);
         end
         wait_ready(2 * FRAME);
      end

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
